// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit framer and its FIFO.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Index of the closing tick: start + data + optional parity + stop bits.
  function automatic int calc_nbits(input int parity_en, input int stop_bits);
    return 1 + DATA_BITS + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with show-ahead read data and an occupancy count.
// Full/empty are decoded from the level register only.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [DATA_BITS-1:0]   i_data,
  input  logic                   i_pop,
  output logic [DATA_BITS-1:0]   o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_level;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: buffers bytes in a FIFO and shifts each one out as
// start / 8 data LSB-first / optional parity / stop bits, one bit per baud
// tick. bps_start enables the external baud generator for one frame only.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic                        clk_bps,
  output logic                        bps_start,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int NBITS = calc_nbits(PARITY_EN, STOP_BITS);
  localparam int IW    = $clog2(NBITS + 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NBITS);
  localparam logic [IW-1:0] IDX_DATA   = IW'(DATA_BITS);
  localparam logic [IW-1:0] IDX_PARITY = IW'(DATA_BITS + 1);
  localparam logic PEN = (PARITY_EN != 0);
  localparam logic ODD = (PARITY_ODD != 0);

  tx_state_e            r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_parity, w_parity_nxt;
  logic [IW-1:0]        r_bit_idx, w_bit_idx_nxt;
  logic                 r_txd, w_txd_nxt;
  logic                 r_bps_start, w_bps_start_nxt;

  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [DATA_BITS-1:0] w_fifo_data;
  logic                 w_pop;
  logic [2:0]           w_data_sel;
  logic                 w_bit_val;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (tx_valid),
    .i_data  (tx_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (fifo_level)
  );

  assign tx_ready  = !w_fifo_full;
  assign txd       = r_txd;
  assign bps_start = r_bps_start;
  assign busy      = (r_state != IDLE) || (fifo_level != '0);

  // Line level for the bit index about to be driven.
  always_comb begin
    w_data_sel = r_bit_idx[2:0] - 3'd1;
    w_bit_val  = STOP_BIT;
    if (r_bit_idx == '0) begin
      w_bit_val = START_BIT;
    end else if (r_bit_idx <= IDX_DATA) begin
      w_bit_val = r_shift[w_data_sel];
    end else if (PEN && (r_bit_idx == IDX_PARITY)) begin
      w_bit_val = r_parity;
    end
  end

  // Next-state and next-output logic; ticks only matter while in SEND.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_parity_nxt    = r_parity;
    w_bit_idx_nxt   = r_bit_idx;
    w_txd_nxt       = r_txd;
    w_bps_start_nxt = r_bps_start;
    w_pop           = 1'b0;
    case (r_state)
      IDLE: begin
        w_txd_nxt       = STOP_BIT;
        w_bps_start_nxt = 1'b0;
        if (!w_fifo_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_fifo_data;
          w_parity_nxt  = (^w_fifo_data) ^ ODD;
          w_bit_idx_nxt = '0;
          w_state_nxt   = LOAD;
        end
      end
      LOAD: begin
        w_bps_start_nxt = 1'b1;
        w_state_nxt     = SEND;
      end
      SEND: begin
        if (clk_bps) begin
          if (r_bit_idx == IDX_LAST) begin
            w_txd_nxt       = STOP_BIT;
            w_bps_start_nxt = 1'b0;
            w_state_nxt     = GAP;
          end else begin
            w_txd_nxt     = w_bit_val;
            w_bit_idx_nxt = r_bit_idx + IW'(1);
          end
        end
      end
      GAP: begin
        // One cycle with the generator disabled so its phase restarts.
        w_bps_start_nxt = 1'b0;
        w_state_nxt     = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; txd comes straight from this flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_bit_idx   <= '0;
      r_txd       <= STOP_BIT;
      r_bps_start <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_parity    <= w_parity_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_txd       <= w_txd_nxt;
      r_bps_start <= w_bps_start_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four configurations, a behavioural baud
// generator per instance, a serial receiver model on instance 0 and
// scoreboards of expected line bits and expected received bytes.
module tb_uart_tx_framer;

  localparam int LIMIT = 20000;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [3:0][7:0] tx_data;
  logic [3:0]      tx_valid;
  logic [3:0]      tx_ready;
  logic [3:0]      clk_bps = '0;
  logic [3:0]      bps_start;
  logic [3:0]      txd;
  logic [3:0]      busy;
  logic [3:0][2:0] fifo_level;

  int         bit_period = 20;
  int         cnt [4];
  int         checks   = 0;
  int         failures = 0;
  bit         bit_q[$];
  logic [7:0] rx_exp_q[$];
  logic [7:0] rx_byte;
  logic [7:0] mb [6];
  int         n, stall, gap;

  always #10 clk = ~clk;

  uart_tx_framer u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .clk_bps(clk_bps[0]), .bps_start(bps_start[0]),
    .txd(txd[0]), .busy(busy[0]), .fifo_level(fifo_level[0]));

  uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .clk_bps(clk_bps[1]), .bps_start(bps_start[1]),
    .txd(txd[1]), .busy(busy[1]), .fifo_level(fifo_level[1]));

  uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .clk_bps(clk_bps[2]), .bps_start(bps_start[2]),
    .txd(txd[2]), .busy(busy[2]), .fifo_level(fifo_level[2]));

  uart_tx_framer #(.STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .clk_bps(clk_bps[3]), .bps_start(bps_start[3]),
    .txd(txd[3]), .busy(busy[3]), .fifo_level(fifo_level[3]));

  // Baud generator model: cleared while bps_start is low, then one tick
  // per bit_period cycles, the first about half a period after enable.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (bps_start[k] !== 1'b1) begin
        cnt[k]     <= 0;
        clk_bps[k] <= 1'b0;
      end else begin
        cnt[k]     <= (cnt[k] == bit_period - 1) ? 0 : cnt[k] + 1;
        clk_bps[k] <= (cnt[k] == bit_period / 2);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame_bits(input logic [7:0] d, input bit pen,
                                          input bit podd, input int nstop);
    bit_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
    if (pen) bit_q.push_back((^d) ^ podd);
    for (int i = 0; i < nstop; i++) bit_q.push_back(1'b1);
  endfunction

  // Offer one byte and hold it until accepted; returns cycles stalled.
  task automatic send_byte(input int k, input logic [7:0] d, output int stalled);
    int w;
    w = 0;
    tx_data[k]  = d;
    tx_valid[k] = 1'b1;
    while (tx_ready[k] !== 1'b1 && w < LIMIT) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= LIMIT) chk("send_timeout", tx_ready[k], 1);
    @(posedge clk); #1;
    tx_valid[k] = 1'b0;
    if (k == 0) rx_exp_q.push_back(d);
    stalled = w;
  endtask

  // Return #1 after the edge on which the DUT consumes the next tick.
  task automatic wait_tick(input int k, input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (clk_bps[k] !== 1'b1 && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    if (w >= LIMIT) chk({tag, "_tick_timeout"}, clk_bps[k], 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_bps(input int k, input logic val, input string tag);
    int w;
    w = 0;
    while (bps_start[k] !== val && w < LIMIT) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= LIMIT) chk(tag, bps_start[k], val);
  endtask

  task automatic wait_idle(input int k, input string tag);
    int w;
    w = 0;
    while (busy[k] !== 1'b0 && w < LIMIT) begin
      @(posedge clk); #1;
      w++;
    end
    chk(tag, busy[k], 0);
  endtask

  // Pop expected bits one per tick, then check the closing tick.
  task automatic check_frame(input int k, input string tag);
    bit e;
    while (bit_q.size() > 0) begin
      e = bit_q.pop_front();
      wait_tick(k, tag);
      chk({tag, "_bit"}, txd[k], e);
    end
    chk({tag, "_bps_hi"}, bps_start[k], 1);
    wait_tick(k, tag);
    chk({tag, "_bps_end"}, bps_start[k], 0);
    chk({tag, "_txd_end"}, txd[k], 1);
  endtask

  // Serial receiver on instance 0: mid-bit sampling from the start edge.
  always begin
    @(negedge txd[0]);
    repeat (bit_period / 2) @(posedge clk);
    #1 chk("rx_start", txd[0], 0);
    for (int b = 0; b < 8; b++) begin
      repeat (bit_period) @(posedge clk);
      #1 rx_byte[b] = txd[0];
    end
    repeat (bit_period) @(posedge clk);
    #1 chk("rx_stop", txd[0], 1);
    chk("rx_expected_pending", rx_exp_q.size() != 0, 1);
    if (rx_exp_q.size() != 0) chk("rx_byte", rx_byte, rx_exp_q.pop_front());
  end

  initial begin
    tx_valid = '0;
    tx_data  = '0;
    mb = '{8'h11, 8'h22, 8'h3C, 8'hF0, 8'h81, 8'h5A};
    #2 rst_n = 1'b0;
    #23;
    chk("rst_txd", txd[0], 1);
    chk("rst_bps_start", bps_start[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_fifo_level", fifo_level[0], 0);
    chk("rst_tx_ready", tx_ready[0], 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single byte, default framing.
    push_frame_bits(8'hA5, 1'b0, 1'b0, 1);
    send_byte(0, 8'hA5, stall);
    check_frame(0, "a5");
    chk("a5_busy_gap", busy[0], 1);
    repeat (2) @(posedge clk);
    #1 chk("a5_busy_idle", busy[0], 0);

    // Even parity, odd parity, two stop bits.
    push_frame_bits(8'h07, 1'b1, 1'b0, 1);
    send_byte(1, 8'h07, stall);
    check_frame(1, "par_even");
    push_frame_bits(8'h07, 1'b1, 1'b1, 1);
    send_byte(2, 8'h07, stall);
    check_frame(2, "par_odd");
    push_frame_bits(8'h00, 1'b0, 1'b0, 2);
    send_byte(3, 8'h00, stall);
    check_frame(3, "stop2");

    // Back-to-back bytes: fill the FIFO, stall, measure inter-frame gaps.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send_byte(0, mb[i], stall);
          if (i == 4) begin
            chk("mb_full_ready", tx_ready[0], 0);
            chk("mb_full_level", fifo_level[0], 4);
          end
          if (i == 5) chk("mb_stalled", stall > 0, 1);
        end
      end
      begin
        for (int g = 0; g < 5; g++) begin
          wait_bps(0, 1'b1, "mb_rise_timeout");
          wait_bps(0, 1'b0, "mb_fall_timeout");
          gap = 0;
          while (bps_start[0] === 1'b0 && gap < 100) begin
            @(posedge clk); #1;
            gap++;
          end
          chk("mb_gap", gap, 3);
        end
      end
    join
    wait_idle(0, "mb_idle");
    chk("mb_rx_drained", rx_exp_q.size(), 0);

    // Real baud rate: each bit of 0x55 alternates, so every interval is one bit.
    bit_period = 434;
    send_byte(0, 8'h55, stall);
    n = 0;
    while (txd[0] !== 1'b0 && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    chk("baud_start_seen", txd[0], 0);
    for (int t = 0; t < 9; t++) begin
      logic prev;
      prev = txd[0];
      n = 0;
      while (txd[0] === prev && n < LIMIT) begin
        @(posedge clk); #1;
        n++;
      end
      chk("baud_bit_len", n, 434);
    end
    wait_idle(0, "baud_idle");
    chk("baud_rx_drained", rx_exp_q.size(), 0);
    bit_period = 20;

    // Reset in the middle of data bit 4, with a second byte still queued.
    send_byte(1, 8'h2C, stall);
    send_byte(1, 8'h81, stall);
    repeat (6) wait_tick(1, "rst_run");
    repeat (7) @(posedge clk);
    #3;
    chk("rst_pre_txd", txd[1], 0);
    chk("rst_pre_level", fifo_level[1], 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_txd", txd[1], 1);
    chk("rst_async_bps", bps_start[1], 0);
    chk("rst_async_level", fifo_level[1], 0);
    chk("rst_async_busy", busy[1], 0);
    #5 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bit_q.delete();
    push_frame_bits(8'hC3, 1'b1, 1'b0, 1);
    send_byte(1, 8'hC3, stall);
    check_frame(1, "post_rst");
    wait_idle(1, "post_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
